// File: rtl/i2c_bit_engine_if.sv
// Command/response and open-drain pad bundle between the I2C command sequencer
// and the bit engine; the engine connects through the slave modport.
interface i2c_bit_engine_if;
    logic       cmd_valid_in;
    logic       cmd_ready_out;
    logic [1:0] cmd_in;
    logic [7:0] wr_data_in;
    logic       rd_ack_in;
    logic [7:0] rd_data_out;
    logic       ack_rx_out;
    logic       done_out;
    logic       bus_held_out;
    logic       scl_oe_out;
    logic       sda_oe_out;
    logic       scl_in;
    logic       sda_in;

    modport master (
        output cmd_valid_in, cmd_in, wr_data_in, rd_ack_in, scl_in, sda_in,
        input  cmd_ready_out, rd_data_out, ack_rx_out, done_out, bus_held_out,
               scl_oe_out, sda_oe_out
    );

    modport slave (
        input  cmd_valid_in, cmd_in, wr_data_in, rd_ack_in, scl_in, sda_in,
        output cmd_ready_out, rd_data_out, ack_rx_out, done_out, bus_held_out,
               scl_oe_out, sda_oe_out
    );
endinterface

// File: rtl/i2c_bit_engine.sv
// I2C bit engine: runs START/STOP/WRITE/READ one quarter-bit phase per tick.
// Optional macro I2C_CLOCK_STRETCH_EN lets a slave holding SCL low stall phase 1.
module i2c_bit_engine #(
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            tick_in,
    i2c_bit_engine_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, STOP, DATA} state_t;

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_STOP  = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd3;

    state_t     state_q, state_d;
    logic       started_q, started_d;
    logic [1:0] phase_q, phase_d;
    logic [3:0] bit_q, bit_d;
    logic       ready_q, ready_d;
    logic       done_q, done_d;
    logic       held_q, held_d;
    logic       scl_oe_q, scl_oe_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       ack_rx_q, ack_rx_d;
    logic       is_read_q, is_read_d;
    logic       rd_ack_q, rd_ack_d;
    logic       sample_q, sample_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [7:0] shift_q, shift_d;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic       sda_s;
    logic       stall;

    always_ff @(posedge clk_in) begin
        sda_sync_q[0] <= bus.sda_in;
        for (int i = 1; i < SYNC_STAGES; i++) sda_sync_q[i] <= sda_sync_q[i-1];
    end
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

`ifdef I2C_CLOCK_STRETCH_EN
    logic [SYNC_STAGES-1:0] scl_sync_q;

    always_ff @(posedge clk_in) begin
        scl_sync_q[0] <= bus.scl_in;
        for (int i = 1; i < SYNC_STAGES; i++) scl_sync_q[i] <= scl_sync_q[i-1];
    end
    // Phase 1 is the SCL-high window in every command; a low readback means a slave is stretching.
    assign stall = started_q && (phase_q == 2'd1) && !scl_sync_q[SYNC_STAGES-1];
`else
    logic unused_scl;
    assign unused_scl = bus.scl_in;
    assign stall      = 1'b0;
`endif

    // Returns {scl_oe, sda_oe} for a given command phase; 1 pulls the line low.
    function automatic logic [1:0] line_drive(state_t st, logic [1:0] ph, logic [3:0] bt,
                                              logic rd, logic [7:0] wr, logic rack);
        logic sda;
        line_drive = 2'b00;
        case (st)
            START: line_drive = {ph == 2'd3, ph >= 2'd2};
            STOP:  line_drive = {ph == 2'd0, ph <= 2'd1};
            DATA: begin
                if (bt[3]) sda = rd ? !rack : 1'b0;
                else       sda = rd ? 1'b0 : !wr[~bt[2:0]];
                line_drive = {(ph == 2'd0) || (ph == 2'd3), sda};
            end
            default: line_drive = 2'b00;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        started_d = started_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        held_d    = held_q;
        scl_oe_d  = scl_oe_q;
        sda_oe_d  = sda_oe_q;
        rd_data_d = rd_data_q;
        ack_rx_d  = ack_rx_q;
        is_read_d = is_read_q;
        rd_ack_d  = rd_ack_q;
        sample_d  = sample_q;
        wr_data_d = wr_data_q;
        shift_d   = shift_q;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid_in && ready_q) begin
                    ready_d   = 1'b0;
                    started_d = 1'b0;
                    is_read_d = (bus.cmd_in == CMD_READ);
                    wr_data_d = bus.wr_data_in;
                    rd_ack_d  = bus.rd_ack_in;
                    case (bus.cmd_in)
                        CMD_START: state_d = START;
                        CMD_STOP:  state_d = STOP;
                        default:   state_d = DATA;
                    endcase
                end
            end
            default: begin
                // The first tick after acceptance only opens phase 0 of bit 0.
                if (tick_in && !started_q) begin
                    started_d = 1'b1;
                    phase_d   = 2'd0;
                    bit_d     = 4'd0;
                    {scl_oe_d, sda_oe_d} = line_drive(state_q, 2'd0, 4'd0,
                                                      is_read_q, wr_data_q, rd_ack_q);
                end else if (tick_in && !stall) begin
                    if (phase_q == 2'd3 && (state_q != DATA || bit_q == 4'd8)) begin
                        state_d   = IDLE;
                        ready_d   = 1'b1;
                        done_d    = 1'b1;
                        started_d = 1'b0;
                        if (state_q == START)     held_d    = 1'b1;
                        else if (state_q == STOP) held_d    = 1'b0;
                        else if (is_read_q)       rd_data_d = shift_q;
                        else                      ack_rx_d  = sample_q;
                    end else begin
                        phase_d = phase_q + 2'd1;
                        bit_d   = (phase_q == 2'd3) ? bit_q + 4'd1 : bit_q;
                        {scl_oe_d, sda_oe_d} = line_drive(state_q, phase_d, bit_d,
                                                          is_read_q, wr_data_q, rd_ack_q);
                        // SDA is sampled at the end of the SCL-high window.
                        if (state_q == DATA && phase_q == 2'd2) begin
                            if (bit_q[3]) sample_d = sda_s;
                            else          shift_d  = {shift_q[6:0], sda_s};
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            started_q <= 1'b0;
            phase_q   <= 2'd0;
            bit_q     <= 4'd0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            held_q    <= 1'b0;
            scl_oe_q  <= 1'b0;
            sda_oe_q  <= 1'b0;
            rd_data_q <= 8'd0;
            ack_rx_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            started_q <= started_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            held_q    <= held_d;
            scl_oe_q  <= scl_oe_d;
            sda_oe_q  <= sda_oe_d;
            rd_data_q <= rd_data_d;
            ack_rx_q  <= ack_rx_d;
        end
    end

    always_ff @(posedge clk_in) begin
        is_read_q <= is_read_d;
        rd_ack_q  <= rd_ack_d;
        sample_q  <= sample_d;
        wr_data_q <= wr_data_d;
        shift_q   <= shift_d;
    end

    assign bus.cmd_ready_out = ready_q;
    assign bus.done_out      = done_q;
    assign bus.bus_held_out  = held_q;
    assign bus.scl_oe_out    = scl_oe_q;
    assign bus.sda_oe_out    = sda_oe_q;
    assign bus.rd_data_out   = rd_data_q;
    assign bus.ack_rx_out    = ack_rx_q;
endmodule

// File: tb/tb_i2c_bit_engine.sv
// Randomized self-checking bench for i2c_bit_engine: each command is expanded into
// its expected per-phase line table, and a slave model drives read data and ACKs.
module tb_i2c_bit_engine;
    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic tick = 1'b0;
    logic slave_sda_pull = 1'b0;
    logic slave_scl_hold = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [1:0] line_exp     = 2'b00;
    logic       bus_held_exp = 1'b0;
    logic [7:0] rd_data_exp  = 8'h00;
    logic       ack_rx_exp   = 1'b0;
    logic [1:0] exp_q[$];

    i2c_bit_engine_if bus();

    i2c_bit_engine #(.SYNC_STAGES(2)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .tick_in(tick),
        .bus    (bus)
    );

    assign bus.sda_in = !(bus.sda_oe_out | slave_sda_pull);
    assign bus.scl_in = !(bus.scl_oe_out | slave_scl_hold);

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        if (obs !== req) begin
            n_err++;
            $display("FAIL %s: observed %0h required %0h at %0t", tag, obs, req, $time);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_outputs(input string tag, input logic done_req, input logic ready_req);
        chk_eq({tag, "_lines"}, 32'({bus.scl_oe_out, bus.sda_oe_out}), 32'(line_exp));
        chk_eq({tag, "_done"},  32'(bus.done_out),      32'(done_req));
        chk_eq({tag, "_ready"}, 32'(bus.cmd_ready_out), 32'(ready_req));
    endtask

    // Expected {scl_oe, sda_oe} for each phase of a command, straight from the bus rules.
    task automatic build_exp(input int c, input logic [7:0] wr, input logic rack);
        exp_q.delete();
        case (c)
            0: exp_q = '{2'b00, 2'b00, 2'b01, 2'b11};
            1: exp_q = '{2'b11, 2'b01, 2'b00, 2'b00};
            default: begin
                for (int b = 0; b < 9; b++) begin
                    logic pull;
                    if (b < 8) pull = (c == 2) ? !wr[7-b] : 1'b0;
                    else       pull = (c == 3) ? !rack : 1'b0;
                    exp_q.push_back({1'b1, pull});
                    exp_q.push_back({1'b0, pull});
                    exp_q.push_back({1'b0, pull});
                    exp_q.push_back({1'b1, pull});
                end
            end
        endcase
    endtask

    task automatic run_cmd(input int c, input logic [7:0] wr, input logic rack,
                           input logic [7:0] sbyte, input logic sack,
                           input int per_lo, input int per_hi,
                           input int stretch_bit, input int rst_at);
        int   total;
        int   ph;
        int   stall_left;
        int   gap;
        int   b;
        logic finished;
        build_exp(c, wr, rack);
        total      = exp_q.size();
        ph         = 0;
        stall_left = 0;
        finished   = 1'b0;

        chk_eq("ready_before_cmd", 32'(bus.cmd_ready_out), 32'd1);
        bus.cmd_valid_in = 1'b1;
        bus.cmd_in       = 2'(c);
        bus.wr_data_in   = wr;
        bus.rd_ack_in    = rack;
        tick             = 1'($urandom_range(0, 1));
        step_clk();
        tick             = 1'b0;
        bus.cmd_valid_in = 1'b0;
        bus.wr_data_in   = 8'($urandom);
        bus.rd_ack_in    = 1'($urandom);
        chk_outputs("accept", 1'b0, 1'b0);

        for (int k = 1; k <= 80 && !finished; k++) begin
            gap = $urandom_range(per_lo, per_hi) - 1;
            repeat (gap) begin
                bus.cmd_valid_in = ($urandom_range(0, 3) == 0);
                bus.cmd_in       = 2'($urandom);
                step_clk();
                chk_eq("gap_done", 32'(bus.done_out), 32'd0);
                chk_eq("gap_lines", 32'({bus.scl_oe_out, bus.sda_oe_out}), 32'(line_exp));
            end
            bus.cmd_valid_in = 1'b0;
            tick = 1'b1;
            if (rst_at == k) rst = 1'b1;
            step_clk();
            tick = 1'b0;

            if (rst_at == k) begin
                rst            = 1'b0;
                line_exp       = 2'b00;
                bus_held_exp   = 1'b0;
                rd_data_exp    = 8'h00;
                ack_rx_exp     = 1'b0;
                slave_sda_pull = 1'b0;
                chk_outputs("midrst", 1'b0, 1'b1);
                chk_eq("midrst_held", 32'(bus.bus_held_out), 32'd0);
                finished = 1'b1;
            end else if (stall_left > 0) begin
                stall_left--;
                chk_outputs("stretch", 1'b0, 1'b0);
                if (stall_left == 0) slave_scl_hold = 1'b0;
            end else if (ph < total) begin
                line_exp = exp_q[ph];
                ph++;
                chk_outputs("phase", 1'b0, 1'b0);
                if (c >= 2 && ((ph - 1) % 4) == 0) begin
                    b = (ph - 1) / 4;
                    if (c == 3 && b < 8)       slave_sda_pull = !sbyte[7-b];
                    else if (c == 2 && b == 8) slave_sda_pull = !sack;
                    else                       slave_sda_pull = 1'b0;
                end
                if (stretch_bit >= 0 && c >= 2 && ph == 4 * stretch_bit + 2) begin
                    slave_scl_hold = 1'b1;
                    stall_left     = 3;
                end
            end else begin
                if (c == 0)      bus_held_exp = 1'b1;
                else if (c == 1) bus_held_exp = 1'b0;
                else if (c == 2) ack_rx_exp   = sack;
                else             rd_data_exp  = sbyte;
                chk_outputs("complete", 1'b1, 1'b1);
                chk_eq("held",    32'(bus.bus_held_out), 32'(bus_held_exp));
                chk_eq("rd_data", 32'(bus.rd_data_out),  32'(rd_data_exp));
                chk_eq("ack_rx",  32'(bus.ack_rx_out),   32'(ack_rx_exp));
                slave_sda_pull = 1'b0;
                step_clk();
                chk_outputs("after_done", 1'b0, 1'b1);
                finished = 1'b1;
            end
        end
        if (!finished) chk_eq("cmd_timeout", 32'd0, 32'd1);
        slave_scl_hold = 1'b0;
        slave_sda_pull = 1'b0;
    endtask

    initial begin
        bus.cmd_valid_in = 1'b0;
        bus.cmd_in       = 2'd0;
        bus.wr_data_in   = 8'h00;
        bus.rd_ack_in    = 1'b0;
        rst              = 1'b1;
        repeat (3) step_clk();
        chk_outputs("reset", 1'b0, 1'b1);
        chk_eq("reset_held",    32'(bus.bus_held_out), 32'd0);
        chk_eq("reset_rd_data", 32'(bus.rd_data_out),  32'd0);
        chk_eq("reset_ack_rx",  32'(bus.ack_rx_out),   32'd0);
        rst = 1'b0;
        step_clk();

        run_cmd(0, 8'h00, 1'b0, 8'h00, 1'b1, 10, 10, -1, 0);
        run_cmd(2, 8'hA5, 1'b0, 8'h00, 1'b0, 10, 10, -1, 0);
        run_cmd(3, 8'h00, 1'b1, 8'h3C, 1'b1, 10, 10, -1, 0);
        run_cmd(1, 8'h00, 1'b0, 8'h00, 1'b1, 10, 10, -1, 0);

        run_cmd(0, 8'h00, 1'b0, 8'h00, 1'b1, 3, 8, -1, 0);
        run_cmd(2, 8'($urandom), 1'b0, 8'h00, 1'b0, 3, 8, -1, 15);
        repeat (30) begin
            tick = ($urandom_range(0, 3) == 0);
            step_clk();
            chk_outputs("post_rst", 1'b0, 1'b1);
            chk_eq("post_rst_held", 32'(bus.bus_held_out), 32'd0);
        end
        tick = 1'b0;
        step_clk();

`ifdef I2C_CLOCK_STRETCH_EN
        run_cmd(0, 8'h00, 1'b0, 8'h00, 1'b1, 4, 6, -1, 0);
        run_cmd(2, 8'h5A, 1'b0, 8'h00, 1'b0, 4, 6, 2, 0);
        run_cmd(3, 8'h00, 1'b0, 8'hC3, 1'b1, 4, 6, 2, 0);
`endif

        repeat (20) begin
            run_cmd($urandom_range(0, 3), 8'($urandom), 1'($urandom), 8'($urandom),
                    1'($urandom), 3, 8, -1, 0);
            repeat ($urandom_range(0, 3)) step_clk();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
